led_chase_scheduler: RTL and testbench

- Sequences the badge LED bank as a chaser: one lit "head" LED advances across NUM_LEDS outputs, and each LED it leaves behind fades out as a trail.
- Per-LED 8-bit brightness is rendered by a shared PWM counter.
- Button events control run/pause, single-step, direction and speed.
- Sits between the debounced/inverted button bus and the top-level LED pins; it replaces ad-hoc counter logic in top.

---
 rtl/led_chase_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_led_chase_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chase_scheduler.sv
// led_chase_scheduler
//
// Drives the badge LED bank as a chaser. A single "head" LED advances one
// position per step. Every LED the head leaves behind fades by a right shift
// on each later step. Per-LED 8-bit brightness is rendered through one shared
// free-running PWM counter.
//
// The buttons are active-high and asynchronous to clk. Bits 0..4 are used:
//   btn[0] run/pause toggle
//   btn[1] single step (honoured only while paused)
//   btn[2] speed up (saturates at 3)
//   btn[3] speed down (saturates at 0)
//   btn[4] direction toggle
//
// Optional build macro LED_GAMMA_EN:
//   defined   -> brightness is gamma-corrected before PWM: eff = (b*b) >> 8
//   undefined -> eff = b, and no multiplier is built
//
// | state  | meaning                                              |
// |--------|------------------------------------------------------|
// | RUN    | divider ticks advance the head                       |
// | PAUSED | head frozen; btn[1] events advance the head one step |

module led_chase_scheduler #(
  parameter int NUM_LEDS   = 11,
  parameter int TICK_DIV   = 1000000,
  parameter int FADE_SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          btn,
  output logic [NUM_LEDS-1:0] led,
  output logic [3:0]          head,
  output logic                tick,
  output logic                paused
);

  // Counter only ever needs to reach TICK_DIV-1 (the speed-0 terminal).
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] TERM0 = CNT_W'((TICK_DIV >> 0) - 1);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'((TICK_DIV >> 1) - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'((TICK_DIV >> 2) - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'((TICK_DIV >> 3) - 1);

  localparam logic [3:0] LAST_IDX = 4'(NUM_LEDS - 1);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_PAUSED = 1'b1
  } state_t;

  state_t             state_q, state_d;

  logic [4:0]         sync1_q, sync2_q, prev_q;
  logic [4:0]         btn_ev;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   term;
  logic               tick_q, tick_d;

  logic [1:0]         speed_q, speed_d;
  logic               dir_q, dir_d;

  logic [3:0]         head_q, head_d;
  logic               step;

  logic [7:0]         bright_q [NUM_LEDS];
  logic [7:0]         eff      [NUM_LEDS];

  logic [7:0]         pwm_q;
  logic [NUM_LEDS-1:0] led_q, led_d;

  logic               unused_btn_hi;

  // Bits 7..5 of the button bus are not wired to any function.
  assign unused_btn_hi = ^btn[7:5];

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn[4:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A held button produces a single one-cycle event.
  assign btn_ev = sync2_q & ~prev_q;

  // Select the divider terminal count for the current speed.
  always_comb begin
    term = TERM0;
    case (speed_q)
      2'd0:    term = TERM0;
      2'd1:    term = TERM1;
      2'd2:    term = TERM2;
      default: term = TERM3;
    endcase
  end

  // Divider: >= (not ==) so a speed increase that leaves the counter above
  // the new terminal wraps and ticks immediately instead of running to 2^N.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q >= term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Speed up/down; simultaneous up and down events cancel.
  always_comb begin
    speed_d = speed_q;
    if (btn_ev[2] && !btn_ev[3] && (speed_q != 2'd3)) begin
      speed_d = speed_q + 2'd1;
    end else if (btn_ev[3] && !btn_ev[2] && (speed_q != 2'd0)) begin
      speed_d = speed_q - 2'd1;
    end
  end

  // Run/pause next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (btn_ev[0]) state_d = S_PAUSED;
      S_PAUSED: if (btn_ev[0]) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // Step gating looks at the pre-transition state, so a tick that lands with
  // a pause toggle still steps when we were running.
  assign step = (tick_q && (state_q == S_RUN)) ||
                (btn_ev[1] && (state_q == S_PAUSED));

  // Direction toggle only affects later steps; a coinciding step uses dir_q.
  assign dir_d = btn_ev[4] ? ~dir_q : dir_q;

  // Next head position, wrapping at both ends of the bank.
  always_comb begin
    head_d = head_q;
    if (step) begin
      if (!dir_q) begin
        head_d = (head_q == LAST_IDX) ? 4'd0 : head_q + 4'd1;
      end else begin
        head_d = (head_q == 4'd0) ? LAST_IDX : head_q - 4'd1;
      end
    end
  end

  // Control registers: FSM state, divider, speed, direction and head.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      speed_q <= 2'd0;
      dir_q   <= 1'b0;
      head_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      head_q  <= head_d;
    end
  end

  // Brightness: on a step the new head is set to full and wins over the fade.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright_q[i] <= 8'd0;
      end
    end else if (step) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (4'(i) == head_d) begin
          bright_q[i] <= 8'hFF;
        end else begin
          bright_q[i] <= bright_q[i] >> FADE_SHIFT;
        end
      end
    end
  end

`ifdef LED_GAMMA_EN
  // Square-law gamma keeps the fading tail perceptually smoother.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      eff[i] = 8'((16'(bright_q[i]) * 16'(bright_q[i])) >> 8);
    end
  end
`else
  // Linear brightness straight into the PWM compare.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      eff[i] = bright_q[i];
    end
  end
`endif

  // PWM compare: eff=0 never lights, eff=255 lights 255 of 256 cycles.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = (eff[i] > pwm_q);
    end
  end

  // Shared PWM counter and registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 8'd0;
      led_q <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
      led_q <= led_d;
    end
  end

  assign led    = led_q;
  assign head   = head_q;
  assign tick   = tick_q;
  assign paused = (state_q == S_PAUSED);

endmodule

// File: tb/tb_led_chase_scheduler.sv
// Testbench for led_chase_scheduler: a reference model predicts every tick
// (cycle, head, paused) into a scoreboard queue and the expected PWM duty of
// every LED into a second queue; independent monitors pop and compare.

module tb_led_chase_scheduler;

  localparam int NUM_LEDS   = 11;
  localparam int TICK_DIV   = 8;
  localparam int FADE_SHIFT = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          btn = 8'd0;
  logic [NUM_LEDS-1:0] led;
  logic [3:0]          head;
  logic                tick;
  logic                paused;

  led_chase_scheduler #(
    .NUM_LEDS  (NUM_LEDS),
    .TICK_DIV  (TICK_DIV),
    .FADE_SHIFT(FADE_SHIFT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .led   (led),
    .head  (head),
    .tick  (tick),
    .paused(paused)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ecnt     = 0;

  // Reference model state
  int m_cnt, m_speed, m_head, m_tick;
  bit m_paused, m_dir;
  int m_bright [NUM_LEDS];
  logic [4:0] ev_at [int];

  typedef struct packed {
    int         cyc;
    logic [3:0] hd;
    logic       ps;
  } tick_exp_t;

  tick_exp_t    tick_q [$];
  logic [127:0] led_q  [$];

  function automatic int eff_of(int b);
`ifdef LED_GAMMA_EN
    return (b * b) / 256;
`else
    return b;
`endif
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock edge of the behavioural model.
  task automatic model_edge();
    logic [4:0] ev;
    bit         stp;
    ev = 5'd0;
    if (ev_at.exists(ecnt)) begin
      ev = ev_at[ecnt];
      ev_at.delete(ecnt);
    end
    if (rst) begin
      m_cnt = 0; m_tick = 0; m_speed = 0; m_head = 0;
      m_paused = 1'b0; m_dir = 1'b0;
      foreach (m_bright[i]) m_bright[i] = 0;
      ev_at.delete();
      return;
    end
    stp = (m_tick == 1 && !m_paused) || (ev[1] && m_paused);
    if (stp) begin
      m_head = m_dir ? (m_head + NUM_LEDS - 1) % NUM_LEDS : (m_head + 1) % NUM_LEDS;
      foreach (m_bright[i]) m_bright[i] = (i == m_head) ? 255 : (m_bright[i] >> FADE_SHIFT);
    end
    if (ev[4]) m_dir = !m_dir;
    if (ev[0]) m_paused = !m_paused;
    if (m_cnt >= (TICK_DIV >> m_speed) - 1) begin
      m_cnt = 0; m_tick = 1;
    end else begin
      m_cnt++; m_tick = 0;
    end
    if (ev[2] && !ev[3] && m_speed < 3) m_speed++;
    else if (ev[3] && !ev[2] && m_speed > 0) m_speed--;
    if (m_tick == 1) tick_q.push_back('{cyc: ecnt, hd: 4'(m_head), ps: m_paused});
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      #1;
      ecnt++;
      model_edge();
    end
  end

  // Tick scoreboard monitor
  initial begin : tick_mon
    tick_exp_t e;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        n_checks++;
        if (tick_q.size() == 0) begin
          n_errors++;
          $display("FAIL tick_unexpected: tick=1 at cycle %0d, expected no tick", ecnt);
        end else begin
          e = tick_q.pop_front();
          if (e.cyc != ecnt || e.hd != head || e.ps != paused) begin
            n_errors++;
            $display("FAIL tick_state: got cycle %0d head %0d paused %0b, expected cycle %0d head %0d paused %0b",
                     ecnt, head, paused, e.cyc, e.hd, e.ps);
          end
        end
      end
    end
  end

  // PWM duty monitor: counts lit cycles per LED over a 256-cycle window
  initial begin : led_mon
    logic [127:0] exp_v;
    int           cnt [NUM_LEDS];
    forever begin
      @(negedge clk);
      if (led_q.size() > 0) begin
        exp_v = led_q.pop_front();
        foreach (cnt[i]) cnt[i] = 0;
        for (int s = 0; s < 256; s++) begin
          foreach (cnt[i]) cnt[i] += int'(led[i]);
          @(negedge clk);
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
          n_checks++;
          if (cnt[i] != int'(exp_v[i*8 +: 8])) begin
            n_errors++;
            $display("FAIL led_duty[%0d]: got %0d lit cycles, expected %0d", i, cnt[i], exp_v[i*8 +: 8]);
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the button bus; rising bits become model events three edges later.
  task automatic set_btn(logic [7:0] v);
    logic [4:0] rise;
    rise = v[4:0] & ~btn[4:0];
    if (rise != 5'd0) begin
      if (ev_at.exists(ecnt + 3)) ev_at[ecnt + 3] = ev_at[ecnt + 3] | rise;
      else ev_at[ecnt + 3] = rise;
    end
    btn = v;
  endtask

  task automatic press(int b, int hold);
    set_btn(btn | (8'd1 << b));
    cyc(hold);
    set_btn(btn & ~(8'd1 << b));
    cyc(4);
  endtask

  task automatic do_reset();
    set_btn(8'd0);
    cyc(5);
    rst = 1'b1;
    cyc(1);
    check("rst_led", int'(led), 0);
    check("rst_head", int'(head), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_paused", int'(paused), 0);
    rst = 1'b0;
  endtask

  task automatic wait_head(int h, int budget);
    int n;
    n = 0;
    while (m_head != h && n < budget) begin
      cyc(1);
      n++;
    end
    if (m_head != h) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_head: model head %0d after %0d cycles, expected %0d", m_head, budget, h);
    end else begin
      check("head_now", int'(head), h);
    end
  endtask

  task automatic expect_leds();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NUM_LEDS; i++) v[i*8 +: 8] = 8'(eff_of(m_bright[i]));
    led_q.push_back(v);
    cyc(262);
  endtask

  initial begin : driver
    logic [7:0] v;

    // Reset and run through a full wrap of the head
    do_reset();
    cyc(8 * 13);

    // Three steps, pause, check fade trail duty
    do_reset();
    wait_head(3, 100);
    press(0, 2);
    check("paused_after_btn0", int'(paused), 1);
    expect_leds();

    // Frozen across ticks, single step with a long-held btn[1]
    cyc(45);
    press(1, 20);
    cyc(20);
    check("single_step_head", int'(head), 4);
    expect_leds();
    press(0, 2);
    check("resumed", int'(paused), 0);
    cyc(40);

    // Reverse direction from head 0: wraps to the last LED
    do_reset();
    press(4, 2);
    wait_head(NUM_LEDS - 1, 30);
    press(0, 2);
    expect_leds();
    press(0, 2);

    // Speed up to saturation, then down past zero
    for (int k = 0; k < 4; k++) press(2, 2);
    cyc(30);
    for (int k = 0; k < 5; k++) press(3, 2);
    cyc(40);

    // Randomized button activity with periodic resets
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 500; c++) begin
        v = btn;
        for (int b = 0; b < 8; b++) begin
          if ($urandom_range(0, 15) == 0) v[b] = ~v[b];
        end
        set_btn(v);
        cyc(1);
      end
      do_reset();
    end

    // Reset mid-run at head 6, then hold paused to confirm dark LEDs
    do_reset();
    wait_head(6, 100);
    do_reset();
    press(0, 1);
    expect_leds();
    press(0, 2);
    cyc(30);

    set_btn(8'd0);
    cyc(10);
    check("tick_queue_drained", tick_q.size(), 0);
    check("led_queue_drained", led_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
